// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake and 2-entry skid buffer
//
// Purpose:
//   One reusable inter-stage latch. A main register drives the outputs. A skid
//   register catches the single entry that can arrive after downstream stalls,
//   because in_ready was already granted from a flop. The control field is
//   forced to zero whenever the stage holds no valid entry. A bubble or a
//   flushed stage therefore never issues a write downstream.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, adds the stall_cnt port. stall_cnt is a saturating 16-bit
//   count of cycles with out_valid && !out_ready. It clears only on reset.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   upstream holds a valid entry
//   in_ready   stage can accept an entry (registered, no path from out_ready)
//   in_ctrl    control field              (CTRL_W)
//   in_data    data payload               (DATA_W)
//   in_tag     destination tag            (TAG_W)
//   flush      synchronous kill of all held entries
//   out_valid  stage holds a valid entry
//   out_ready  downstream accepts this cycle
//   out_ctrl   control field, zero when out_valid is low
//   out_data   payload (stale when invalid)
//   out_tag    tag (stale when invalid)
//   stall_cnt  back-pressured cycle count (PIPE_STAGE_PERF_EN only)

module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [TAG_W-1:0]  main_tag;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [TAG_W-1:0]  skid_tag;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Both valids decode directly from the state flop. in_ready therefore
    // depends only on registered state.
    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
    assign out_data = main_data;
    assign out_tag  = main_tag;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Any same-cycle input is dropped. A same-cycle output fire has
            // already been taken by downstream, so clearing is still correct.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the skid entry moves forward.
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            main_tag  <= '0;
        end else if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            main_tag  <= in_tag;
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            main_tag  <= skid_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            skid_tag  <= in_tag;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating stall counter. flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 5;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    int errors;
    int checks;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_tag  (out_tag)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_tag   = d[TAG_W-1:0] ^ 5'h1F;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, '0, '0);
        flush = 1'b0;
        out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 64'hAB, 4'hF);
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
        checks++;
        if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        // Inputs must be ignored while reset is held.
        cyc();
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || out_tag !== 5'h0) begin
            errors++;
            $display("FAIL reset_ignore_inputs: got v=%0h c=%0h t=%0h expected 0 0 0", out_valid, out_ctrl, out_tag);
        end
        drive(1'b0, '0, '0);
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 64'(k), 4'b1001);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready_%0d: got %0h expected 1", k, in_ready); end
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'(k) || out_ctrl !== 4'b1001) begin
                errors++;
                $display("FAIL stream_out_%0d: got v=%0h d=%0h c=%0h expected 1 %0h 9", k, out_valid, out_data, out_ctrl, k);
            end
            checks++;
            if (out_tag !== (5'(k) ^ 5'h1F)) begin
                errors++;
                $display("FAIL stream_tag_%0d: got %0h expected %0h", k, out_tag, 5'(k) ^ 5'h1F);
            end
        end
        drive(1'b0, '0, '0);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin
            errors++;
            $display("FAIL stream_drain: got v=%0h c=%0h expected 0 0", out_valid, out_ctrl);
        end
    endtask

    task automatic test_back_pressure();
        logic [DATA_W-1:0] exp_seq [4];
        exp_seq[0] = 64'd2;
        exp_seq[1] = 64'd3;
        exp_seq[2] = 64'd4;
        exp_seq[3] = 64'd0;
        out_ready = 1'b1;
        drive(1'b1, 64'd1, 4'h3);
        cyc();
        checks++;
        if (out_data !== 64'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got v=%0h d=%0h expected 1 1", out_valid, out_data);
        end
        out_ready = 1'b0;
        drive(1'b1, 64'd2, 4'h3);
        cyc();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 64'd1) begin
            errors++;
            $display("FAIL bp_skid_full: got rdy=%0h d=%0h expected 0 1", in_ready, out_data);
        end
        drive(1'b1, 64'd3, 4'h3);
        cyc();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 64'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%0h v=%0h d=%0h expected 0 1 1", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drive(1'b1, 64'd4, 4'h3);
            if (i == 3) drive(1'b0, '0, '0);
            cyc();
            checks++;
            if (i < 3) begin
                if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: got v=%0h d=%0h expected 1 %0h", i, out_valid, out_data, exp_seq[i]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_empty: got v=%0h expected 0", out_valid);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 64'd7, 4'hF);
        cyc();
        drive(1'b1, 64'd8, 4'hF);
        cyc();
        checks++;
        if (in_ready !== 1'b0 || out_ctrl !== 4'hF) begin
            errors++;
            $display("FAIL flush_setup_full: got rdy=%0h c=%0h expected 0 f", in_ready, out_ctrl);
        end
        flush = 1'b1;
        drive(1'b1, 64'd9, 4'hF);
        cyc();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got v=%0h c=%0h rdy=%0h expected 0 0 1", out_valid, out_ctrl, in_ready);
        end
        // Flush in ONE, where in_ready is high, must still drop the new entry.
        drive(1'b1, 64'd5, 4'hF);
        cyc();
        flush = 1'b1;
        drive(1'b1, 64'd9, 4'hF);
        cyc();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_one: got v=%0h c=%0h rdy=%0h expected 0 0 1", out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: got v=%0h d=%0h expected v=0", out_valid, out_data);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b1;
        drive(1'b1, 64'h20, 4'h6);
        cyc();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 64'h20 + 64'(i), 4'h6);
            cyc();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 64'h20 + 64'(i)) begin
                errors++;
                $display("FAIL simul_%0d: got rdy=%0h v=%0h d=%0h expected 1 1 %0h", i, in_ready, out_valid, out_data, 64'h20 + 64'(i));
            end
        end
        drive(1'b0, '0, '0);
        cyc();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 64'h31, 4'hF);
        cyc();
        drive(1'b1, 64'h32, 4'hF);
        cyc();
        drive(1'b0, '0, '0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got v=%0h c=%0h d=%0h rdy=%0h expected 0 0 0 1", out_valid, out_ctrl, out_data, in_ready);
        end
        cyc();
        rst = 1'b1;
        cyc();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (stall_cnt !== 16'h0) begin errors++; $display("FAIL perf_reset: got %0h expected 0", stall_cnt); end
        out_ready = 1'b0;
        drive(1'b1, 64'h44, 4'h1);
        cyc();
        drive(1'b0, '0, '0);
        repeat (3) cyc();
        checks++;
        if (stall_cnt !== 16'd3) begin errors++; $display("FAIL perf_count3: got %0h expected 3", stall_cnt); end
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_saturate: got %0h expected ffff", stall_cnt); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_flush: got %0h expected ffff", stall_cnt); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_simultaneous();
        test_reset_mid();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
